vga_timing_gen: RTL and testbench

VGA 640x480@60 Hz timing generator that drives the `HCount`/`VCount` pixel-coordinate bus consumed by the card renderers. It also produces the active-low `hsync`/`vsync` strobes and registers the merged renderer colour onto the 3-bit DAC pins. The sync strobes and the colour output leave through a one-pixel alignment pipeline, so they always match each other. The block sits between the system clock and the VGA connector; renderers are purely combinational on `HCount`/`VCount`.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/pixel_divider.sv | 34 +++
 rtl/vga_timing_gen.sv | 103 ++++++++++
 tb/tb_vga_timing_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 Hz timing constants and shared widths for the VGA timing generator.
package vga_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 3;

  // Inclusive window test on a coordinate, bounds given in pixels/lines.
  function automatic logic in_window(input logic [COORD_W-1:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) <= hi);
  endfunction

endpackage

// File: rtl/pixel_divider.sv
// rtl/pixel_divider.sv - system-clock to pixel-rate divider producing a one-clock pixel_tick.
module pixel_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pixel_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Decoded from the registered count so the tick is low out of reset.
  assign pixel_tick = (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA H/V counters, sync/blank decode and one-pixel colour/sync alignment stage.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] rgb_in,
  output logic [COORD_W-1:0] HCount,
  output logic [COORD_W-1:0] VCount,
  output logic               pixel_tick,
  output logic               video_on,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] rgb_out
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_FIRST = H_VISIBLE + H_FRONT;
  localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST = V_VISIBLE + V_FRONT;
  localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

  logic [COORD_W-1:0] hcount_q, hcount_d;
  logic [COORD_W-1:0] vcount_q, vcount_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               frame_start_q, frame_start_d;

  logic h_last, v_last, hs_win, vs_win;

  pixel_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .pixel_tick(pixel_tick)
  );

  assign h_last   = (hcount_q == COORD_W'(H_TOTAL - 1));
  assign v_last   = (vcount_q == COORD_W'(V_TOTAL - 1));
  assign hs_win   = in_window(hcount_q, HS_FIRST, HS_LAST);
  assign vs_win   = in_window(vcount_q, VS_FIRST, VS_LAST);
  assign video_on = (int'(hcount_q) < H_VISIBLE) && (int'(vcount_q) < V_VISIBLE);

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    if (pixel_tick) begin
      hcount_d = h_last ? '0 : hcount_q + 1'b1;
      if (h_last) begin
        vcount_d = v_last ? '0 : vcount_q + 1'b1;
      end
      frame_start_d = h_last && v_last;
      // Alignment stage: colour and syncs describe the pixel just left.
      rgb_d   = video_on ? rgb_in : '0;
      hsync_d = ~hs_win;
      vsync_d = ~vs_win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign HCount      = hcount_q;
  assign VCount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_out     = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a reduced 30x15 raster.
module tb_vga_timing_gen;

  localparam int D  = 2;
  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rgb_in = 3'b000;
  logic [9:0] HCount, VCount;
  logic       pixel_tick, video_on, frame_start, hsync, vsync;
  logic [2:0] rgb_out;

  int checks = 0;
  int errors = 0;
  int n = 0;
  bit run = 1'b0;
  bit rec = 1'b0;

  int hs_first = -1, hs_run = 0, hs_len = 0;
  int vs_first = -1, vs_run = 0, vs_len = 0;
  int fs_hi = 0, fs_num = 0;
  int fs_n[4];

  vga_timing_gen #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rgb_in     (rgb_in),
    .HCount     (HCount),
    .VCount     (VCount),
    .pixel_tick (pixel_tick),
    .video_on   (video_on),
    .frame_start(frame_start),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb_out    (rgb_out)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset was last released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  function automatic logic [2:0] good(input int q);
    return (q < HT * VT) ? 3'b101 : 3'((q % 7) + 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d (n=%0d)", name, act, exp, n);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " HCount"}, int'(HCount), 0);
    chk({tag, " VCount"}, int'(VCount), 0);
    chk({tag, " pixel_tick"}, int'(pixel_tick), 0);
    chk({tag, " video_on"}, int'(video_on), 1);
    chk({tag, " frame_start"}, int'(frame_start), 0);
    chk({tag, " hsync"}, int'(hsync), 1);
    chk({tag, " vsync"}, int'(vsync), 1);
    chk({tag, " rgb_out"}, int'(rgb_out), 0);
  endtask

  task automatic wait_n(input int target);
    int guard = 0;
    while (n != target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (n != target) begin
      checks++;
      errors++;
      $display("FAIL wait_n timeout: got n=%0d expected n=%0d", n, target);
    end
  endtask

  // Colour driver: the real pixel colour only during the tick clock, garbage otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rgb_in = (n % D == D - 1) ? good(n / D) : ~good(n / D);
    end
  end

  // Model: everything follows from the number of edges since release.
  always @(negedge clk) begin
    int p, h, v, pp, ph, pv;
    int e_hs, e_vs, e_rgb, e_fs;
    if (run) begin
      p    = n / D;
      h    = p % HT;
      v    = (p / HT) % VT;
      e_fs = (n > 0 && n % D == 0 && p % (HT * VT) == 0) ? 1 : 0;
      if (p == 0) begin
        e_hs = 1; e_vs = 1; e_rgb = 0;
      end else begin
        pp    = p - 1;
        ph    = pp % HT;
        pv    = (pp / HT) % VT;
        e_hs  = (ph >= HV + HF && ph < HV + HF + HS) ? 0 : 1;
        e_vs  = (pv >= VV + VF && pv < VV + VF + VS) ? 0 : 1;
        e_rgb = (ph < HV && pv < VV) ? int'(good(pp)) : 0;
      end
      chk("m HCount", int'(HCount), h);
      chk("m VCount", int'(VCount), v);
      chk("m pixel_tick", int'(pixel_tick), (n % D == D - 1) ? 1 : 0);
      chk("m video_on", int'(video_on), (h < HV && v < VV) ? 1 : 0);
      chk("m frame_start", int'(frame_start), e_fs);
      chk("m hsync", int'(hsync), e_hs);
      chk("m vsync", int'(vsync), e_vs);
      chk("m rgb_out", int'(rgb_out), e_rgb);
    end
  end

  // Pulse-width and edge-position recorder for the first two frames.
  always @(negedge clk) begin
    if (rec) begin
      if (!hsync) begin
        if (hs_first < 0) hs_first = n;
        hs_run++;
      end else if (hs_run > 0) begin
        hs_len = hs_run;
        hs_run = 0;
      end
      if (!vsync) begin
        if (vs_first < 0) vs_first = n;
        vs_run++;
      end else if (vs_run > 0) begin
        vs_len = vs_run;
        vs_run = 0;
      end
      if (frame_start) begin
        fs_hi++;
        if (fs_num < 4) fs_n[fs_num] = n;
        fs_num++;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("reset hold");
    run = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    rec = 1'b1;

    @(negedge clk);
    chk("clock2 pixel_tick", int'(pixel_tick), 1);
    chk("clock2 HCount", int'(HCount), 0);
    @(negedge clk);
    chk("clock3 HCount", int'(HCount), 1);
    chk("clock3 pixel_tick", int'(pixel_tick), 0);

    wait_n(59);
    chk("line end HCount", int'(HCount), 29);
    chk("line end VCount", int'(VCount), 0);
    @(negedge clk);
    chk("line wrap HCount", int'(HCount), 0);
    chk("line wrap VCount", int'(VCount), 1);
    chk("line wrap frame_start", int'(frame_start), 0);

    wait_n(899);
    chk("frame end HCount", int'(HCount), 29);
    chk("frame end VCount", int'(VCount), 14);
    @(negedge clk);
    chk("frame wrap HCount", int'(HCount), 0);
    chk("frame wrap VCount", int'(VCount), 0);
    chk("frame wrap frame_start", int'(frame_start), 1);
    @(negedge clk);
    chk("frame_start width", int'(frame_start), 0);

    // Mid-line reset in the visible area of the third frame, pixel (8,3).
    wait_n(1997);
    rec = 1'b0;
    chk("pre-reset HCount", int'(HCount), 8);
    chk("pre-reset VCount", int'(VCount), 3);
    chk("pre-reset rgb_out", int'(rgb_out), 3'b100);
    chk("hsync first low n", hs_first, 42);
    chk("hsync low clocks", hs_len, HS * D);
    chk("vsync first low n", vs_first, 602);
    chk("vsync low clocks", vs_len, VS * HT * D);
    chk("frame_start pulses", fs_num, 2);
    chk("frame_start high clocks", fs_hi, 2);
    chk("first frame_start n", fs_n[0], 900);
    chk("frame period", fs_n[1] - fs_n[0], HT * VT * D);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async reset visible");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Second reset inside both sync windows, pixel (22,10).
    wait_n(645);
    chk("pre-reset2 hsync", int'(hsync), 0);
    chk("pre-reset2 vsync", int'(vsync), 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async reset sync");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("restart HCount", int'(HCount), 10);
    chk("restart VCount", int'(VCount), 1);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
